// File: rtl/io_bus_pkg.sv
// io_bus_pkg -- shared types and constants for the memory-mapped I/O bus
// controller.
//   state_t        : controller FSM states (IDLE -> WAIT -> DONE -> IDLE)
//   op_t           : access direction latched for the duration of an access
//   SEL_*_DEFAULT  : default position/width of the region-select field
//   ERR_DATA       : read data returned to the CPU when an access fails
package io_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

  // Region index = cpu_addr[SEL_LSB +: SEL_W]; 4 bits select up to 16 regions.
  localparam int SEL_LSB_DEFAULT = 28;
  localparam int SEL_W_DEFAULT   = 4;
  localparam int MAX_SLV         = 1 << SEL_W_DEFAULT;

  localparam int unsigned ERR_DATA = 0;

endpackage

// File: rtl/io_bus_ctrl_if.sv
// io_bus_ctrl_if -- CPU data port plus shared peripheral bus.
//   CPU side   : cpu_addr/cpu_re/cpu_we/cpu_wdata in, cpu_rdata/cpu_stall/cpu_err out
//   Slave side : slv_addr/slv_wdata shared, slv_re/slv_we one-hot strobes,
//                slv_rdata flattened (slave i at [i*DATA_W +: DATA_W]), slv_ack
// modport master : the bus controller
// modport slave  : the environment (CPU data port and peripherals)
interface io_bus_ctrl_if #(
  parameter int NUM_SLV = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
);

  logic [ADDR_W-1:0]         cpu_addr;
  logic                      cpu_re;
  logic                      cpu_we;
  logic [DATA_W-1:0]         cpu_wdata;
  logic [DATA_W-1:0]         cpu_rdata;
  logic                      cpu_stall;
  logic                      cpu_err;

  logic [ADDR_W-1:0]         slv_addr;
  logic [DATA_W-1:0]         slv_wdata;
  logic [NUM_SLV-1:0]        slv_re;
  logic [NUM_SLV-1:0]        slv_we;
  logic [NUM_SLV*DATA_W-1:0] slv_rdata;
  logic [NUM_SLV-1:0]        slv_ack;

  modport master (
    input  cpu_addr, cpu_re, cpu_we, cpu_wdata, slv_rdata, slv_ack,
    output cpu_rdata, cpu_stall, cpu_err, slv_addr, slv_wdata, slv_re, slv_we
  );

  modport slave (
    output cpu_addr, cpu_re, cpu_we, cpu_wdata, slv_rdata, slv_ack,
    input  cpu_rdata, cpu_stall, cpu_err, slv_addr, slv_wdata, slv_re, slv_we
  );

endinterface

// File: rtl/io_bus_decode.sv
// io_bus_decode -- combinational address/op decoder.
//   cpu_addr, cpu_re, cpu_we : current CPU request
//   idx   : region-select field of cpu_addr
//   valid : exactly one of re/we asserted and idx maps to an existing slave
//   op    : OP_WRITE when cpu_we, otherwise OP_READ
module io_bus_decode
  import io_bus_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int NUM_SLV = 4,
  parameter int SEL_LSB = SEL_LSB_DEFAULT,
  parameter int SEL_W   = SEL_W_DEFAULT
) (
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_re,
  input  logic              cpu_we,
  output logic [SEL_W-1:0]  idx,
  output logic              valid,
  output op_t               op
);

  // Only the select field matters here; the rest of the address is the
  // slave's business.
  logic addr_unused;
  assign addr_unused = ^cpu_addr;

  assign idx   = cpu_addr[SEL_LSB +: SEL_W];
  // Simultaneous read and write is meaningless and reported as a decode error.
  assign valid = (cpu_re ^ cpu_we) && (int'(idx) < NUM_SLV);
  assign op    = cpu_we ? OP_WRITE : OP_READ;

endmodule

// File: rtl/io_bus_ctrl.sv
// io_bus_ctrl -- request/ack I/O bus controller between the CPU data port and
// NUM_SLV peripherals.
//   clk, rstn : bus clock, asynchronous active-low reset
//   bus       : io_bus_ctrl_if master modport (CPU port + shared slave bus)
//   err_count : saturating count of failed accesses (decode error or timeout)
//   err_addr  : address of the most recent failed access
// An access stalls the CPU in IDLE (request seen) and every WAIT cycle, then
// presents cpu_rdata/cpu_err for one unstalled DONE cycle.
module io_bus_ctrl
  import io_bus_pkg::*;
#(
  parameter int NUM_SLV  = 4,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int SEL_LSB  = SEL_LSB_DEFAULT,
  parameter int SEL_W    = SEL_W_DEFAULT,
  parameter int TIMEOUT  = 15,
  parameter int ERRCNT_W = 8
) (
  input  logic                clk,
  input  logic                rstn,
  io_bus_ctrl_if.master       bus,
  output logic [ERRCNT_W-1:0] err_count,
  output logic [ADDR_W-1:0]   err_addr
);

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t               state_reg, state_next;

  logic [SEL_W-1:0]     dec_idx;
  logic                 dec_valid;
  op_t                  dec_op;
  logic [NUM_SLV-1:0]   dec_onehot;

  logic                 req;
  logic                 ack_hit;
  logic                 ev_start, ev_dec_err, ev_ack, ev_tmo;

  logic [ADDR_W-1:0]    addr_reg;
  logic [DATA_W-1:0]    wdata_reg;
  logic [NUM_SLV-1:0]   re_reg, we_reg;
  logic [7:0]           tmo_reg;
  logic [DATA_W-1:0]    rdata_reg;
  logic                 err_reg;
  logic [ERRCNT_W-1:0]  err_count_reg;
  logic [ADDR_W-1:0]    err_addr_reg;

  logic [DATA_W-1:0]    rd_slice [NUM_SLV];
  logic [DATA_W-1:0]    rd_mux;

  io_bus_decode #(
    .ADDR_W  (ADDR_W),
    .NUM_SLV (NUM_SLV),
    .SEL_LSB (SEL_LSB),
    .SEL_W   (SEL_W)
  ) u_decode (
    .cpu_addr (bus.cpu_addr),
    .cpu_re   (bus.cpu_re),
    .cpu_we   (bus.cpu_we),
    .idx      (dec_idx),
    .valid    (dec_valid),
    .op       (dec_op)
  );

  assign req = bus.cpu_re | bus.cpu_we;

  // The strobe registers double as the latched one-hot slave select, so the
  // ack match and the read mux need no separate index register.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLV; gi++) begin : g_slv
      assign dec_onehot[gi] = (dec_idx == SEL_W'(gi));
      assign rd_slice[gi]   = re_reg[gi] ? bus.slv_rdata[gi*DATA_W +: DATA_W] : '0;
    end
  endgenerate

  // AND-OR mux; a write selects nothing and therefore returns 0.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      rd_mux = rd_mux | rd_slice[i];
    end
  end

  // Acks from slaves that are not being strobed are masked out.
  assign ack_hit = |(bus.slv_ack & (re_reg | we_reg));

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    ev_start   = 1'b0;
    ev_dec_err = 1'b0;
    ev_ack     = 1'b0;
    ev_tmo     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req) begin
          if (dec_valid) begin
            ev_start   = 1'b1;
            state_next = WAIT;
          end else begin
            ev_dec_err = 1'b1;
            state_next = DONE;
          end
        end
      end
      WAIT: begin
        // An ack in the final allowed cycle still wins over the timeout.
        if (ack_hit) begin
          ev_ack     = 1'b1;
          state_next = DONE;
        end else if (tmo_reg == TMO_LAST) begin
          ev_tmo     = 1'b1;
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign bus.cpu_stall = ((state_reg == IDLE) && req) || (state_reg == WAIT);

  // ---------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      addr_reg      <= '0;
      wdata_reg     <= '0;
      re_reg        <= '0;
      we_reg        <= '0;
      tmo_reg       <= '0;
      rdata_reg     <= '0;
      err_reg       <= 1'b0;
      err_count_reg <= '0;
      err_addr_reg  <= '0;
    end else begin
      if (ev_start) begin
        addr_reg  <= bus.cpu_addr;
        wdata_reg <= bus.cpu_wdata;
        re_reg    <= (dec_op == OP_READ)  ? dec_onehot : '0;
        we_reg    <= (dec_op == OP_WRITE) ? dec_onehot : '0;
        tmo_reg   <= '0;
      end

      if ((state_reg == WAIT) && !ev_ack && !ev_tmo) begin
        tmo_reg <= tmo_reg + 8'd1;
      end

      if (ev_ack) begin
        rdata_reg <= rd_mux;
        err_reg   <= 1'b0;
      end

      if (ev_ack || ev_tmo) begin
        re_reg <= '0;
        we_reg <= '0;
      end

      if (ev_tmo || ev_dec_err) begin
        rdata_reg    <= DATA_W'(ERR_DATA);
        err_reg      <= 1'b1;
        err_addr_reg <= ev_tmo ? addr_reg : bus.cpu_addr;
        if (err_count_reg != '1) begin
          err_count_reg <= err_count_reg + ERRCNT_W'(1);
        end
      end
    end
  end

  assign bus.slv_addr  = addr_reg;
  assign bus.slv_wdata = wdata_reg;
  assign bus.slv_re    = re_reg;
  assign bus.slv_we    = we_reg;
  assign bus.cpu_rdata = rdata_reg;
  assign bus.cpu_err   = err_reg;
  assign err_count     = err_count_reg;
  assign err_addr      = err_addr_reg;

endmodule

// File: tb/tb_io_bus_ctrl.sv
// tb_io_bus_ctrl -- self-checking bench for io_bus_ctrl.
// The driver plays an access as a timeline (IDLE cycle, L WAIT cycles, one
// DONE cycle) and queues the outputs each cycle must show, using a
// transaction-level model of the CPU-visible results. One compare process
// checks every queued cycle on the falling edge.
module tb_io_bus_ctrl;

  localparam int NS  = 4;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 15;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [7:0]    err_count;
  logic [AW-1:0] err_addr;

  always #5 clk = ~clk;

  io_bus_ctrl_if #(.NUM_SLV(NS), .ADDR_W(AW), .DATA_W(DW)) bus ();

  io_bus_ctrl #(
    .NUM_SLV  (NS),
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .SEL_LSB  (28),
    .SEL_W    (4),
    .TIMEOUT  (TMO),
    .ERRCNT_W (8)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .bus       (bus.master),
    .err_count (err_count),
    .err_addr  (err_addr)
  );

  typedef struct {
    logic        stall;
    logic [3:0]  re;
    logic [3:0]  we;
    logic        chk_slv;
    logic [31:0] saddr;
    logic [31:0] swdata;
    logic [31:0] rdata;
    logic        err;
    logic [7:0]  cnt;
    logic [31:0] eaddr;
  } exp_t;

  exp_t expq[$];

  int n_tests = 0;
  int n_fail  = 0;
  int n_txn   = 0;

  // CPU-visible model state
  logic [31:0] m_rdata;
  logic        m_err;
  int          m_cnt;
  logic [31:0] m_eaddr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic stall, input logic [3:0] re, input logic [3:0] we,
                              input logic chk_slv, input logic [31:0] saddr,
                              input logic [31:0] swdata);
    exp_t e;
    e.stall   = stall;
    e.re      = re;
    e.we      = we;
    e.chk_slv = chk_slv;
    e.saddr   = saddr;
    e.swdata  = swdata;
    e.rdata   = m_rdata;
    e.err     = m_err;
    e.cnt     = 8'(m_cnt);
    e.eaddr   = m_eaddr;
    return e;
  endfunction

  task automatic model_reset();
    m_rdata = '0;
    m_err   = 1'b0;
    m_cnt   = 0;
    m_eaddr = '0;
  endtask

  task automatic model_fail(input logic [31:0] addr);
    m_rdata = '0;
    m_err   = 1'b1;
    m_eaddr = addr;
    if (m_cnt < 255) m_cnt++;
  endtask

  task automatic rand_rdata();
    for (int i = 0; i < NS; i++) bus.slv_rdata[i*DW +: DW] = $urandom;
  endtask

  task automatic drop_req();
    bus.cpu_re  = 1'b0;
    bus.cpu_we  = 1'b0;
    bus.slv_ack = '0;
    rand_rdata();
  endtask

  // Compare process: one queued expectation per clock cycle.
  always @(negedge clk) begin : compare
    exp_t e;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      chk("cpu_stall", 32'(bus.cpu_stall), 32'(e.stall));
      chk("slv_re", 32'(bus.slv_re), 32'(e.re));
      chk("slv_we", 32'(bus.slv_we), 32'(e.we));
      chk("cpu_rdata", bus.cpu_rdata, e.rdata);
      chk("cpu_err", 32'(bus.cpu_err), 32'(e.err));
      chk("err_count", 32'(err_count), 32'(e.cnt));
      chk("err_addr", err_addr, e.eaddr);
      if (e.chk_slv) begin
        chk("slv_addr", bus.slv_addr, e.saddr);
        chk("slv_wdata", bus.slv_wdata, e.swdata);
      end
    end
  end

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      drop_req();
      bus.cpu_addr  = $urandom;
      bus.cpu_wdata = $urandom;
      expq.push_back(mk(1'b0, 4'b0, 4'b0, 1'b0, '0, '0));
    end
  endtask

  // lat: WAIT cycle (1-based) in which the selected slave acks; 0 = never.
  // abort_w: WAIT cycle in which reset is pulsed; 0 = no reset.
  task automatic do_access(input bit is_wr, input bit both, input logic [31:0] addr,
                           input logic [31:0] wdata, input int lat,
                           input logic [31:0] rd, input int abort_w);
    int         idx;
    bit         dec_err;
    int         nwait;
    logic [3:0] oh;
    idx     = int'(addr[31:28]);
    dec_err = both || (idx >= NS);
    n_txn++;
    $display("[TB] txn %0d: %s addr=%h wdata=%h lat=%0d abort=%0d", n_txn,
             both ? "rd+wr" : (is_wr ? "wr" : "rd"), addr, wdata, lat, abort_w);

    @(posedge clk); #1;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wdata;
    bus.cpu_re    = !is_wr || both;
    bus.cpu_we    = is_wr || both;
    bus.slv_ack   = 4'($urandom);
    rand_rdata();
    expq.push_back(mk(1'b1, 4'b0, 4'b0, 1'b0, '0, '0));

    if (dec_err) begin
      @(posedge clk); #1;
      drop_req();
      model_fail(addr);
      expq.push_back(mk(1'b0, 4'b0, 4'b0, 1'b0, '0, '0));
      return;
    end

    oh    = 4'(1 << idx);
    nwait = (lat > 0) ? lat : TMO;
    for (int w = 1; w <= nwait; w++) begin
      @(posedge clk); #1;
      if (w == abort_w) begin
        rstn = 1'b0;
        drop_req();
        model_reset();
        expq.push_back(mk(1'b0, 4'b0, 4'b0, 1'b1, '0, '0));
        @(posedge clk); #1;
        rstn        = 1'b1;
        bus.slv_ack = oh;  // late ack from the aborted slave
        expq.push_back(mk(1'b0, 4'b0, 4'b0, 1'b1, '0, '0));
        @(posedge clk); #1;
        bus.slv_ack = '0;
        expq.push_back(mk(1'b0, 4'b0, 4'b0, 1'b1, '0, '0));
        return;
      end
      // Unselected slaves chatter; on a never-acked access they all ack.
      bus.slv_ack = (lat == 0) ? ~oh : (4'($urandom) & ~oh);
      if (w == lat) bus.slv_ack = bus.slv_ack | oh;
      rand_rdata();
      if (w == lat) bus.slv_rdata[idx*DW +: DW] = rd;
      expq.push_back(mk(1'b1, is_wr ? 4'b0 : oh, is_wr ? oh : 4'b0, 1'b1, addr, wdata));
    end

    @(posedge clk); #1;
    drop_req();
    if (lat > 0) begin
      m_err   = 1'b0;
      m_rdata = is_wr ? '0 : rd;
    end else begin
      model_fail(addr);
    end
    expq.push_back(mk(1'b0, 4'b0, 4'b0, 1'b0, '0, '0));
  endtask

  initial begin : driver
    int          kind;
    logic [31:0] a;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    bus.cpu_re    = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.slv_ack   = '0;
    bus.slv_rdata = '0;
    model_reset();

    // Reset state
    repeat (2) begin
      @(posedge clk); #1;
      expq.push_back(mk(1'b0, 4'b0, 4'b0, 1'b1, '0, '0));
    end
    @(posedge clk); #1;
    rstn = 1'b1;
    expq.push_back(mk(1'b0, 4'b0, 4'b0, 1'b1, '0, '0));
    idle_cycles(2);

    // Read slave 1, immediate ack
    do_access(1'b0, 1'b0, 32'h1000_0010, 32'h0, 1, 32'hCAFE_F00D, 0);
    @(negedge clk);
    chk("tp1_rdata", bus.cpu_rdata, 32'hCAFE_F00D);
    chk("tp1_err", 32'(bus.cpu_err), 32'd0);
    idle_cycles(1);

    // Write slave 2, ack in 5th WAIT cycle
    do_access(1'b1, 1'b0, 32'h2000_0000, 32'h0000_00AA, 5, 32'h0, 0);
    @(negedge clk);
    chk("tp2_err", 32'(bus.cpu_err), 32'd0);
    chk("tp2_rdata", bus.cpu_rdata, 32'd0);

    // Decode error on an unmapped region
    do_access(1'b0, 1'b0, 32'h7000_0000, 32'h0, 1, 32'h0, 0);
    @(negedge clk);
    chk("tp3_err", 32'(bus.cpu_err), 32'd1);
    chk("tp3_err_addr", err_addr, 32'h7000_0000);
    chk("tp3_err_count", 32'(err_count), 32'd1);

    // Timeout on slave 3 with other slaves acking
    do_access(1'b0, 1'b0, 32'h3000_0004, 32'h0, 0, 32'h0, 0);
    @(negedge clk);
    chk("tp4_err", 32'(bus.cpu_err), 32'd1);
    chk("tp4_rdata", bus.cpu_rdata, 32'd0);
    chk("tp4_err_count", 32'(err_count), 32'd2);
    chk("tp4_err_addr", err_addr, 32'h3000_0004);

    // Reset during WAIT on slave 0, then a normal read
    do_access(1'b0, 1'b0, 32'h0000_0100, 32'h0, 0, 32'h0, 3);
    @(negedge clk);
    chk("tp6_err_count", 32'(err_count), 32'd0);
    chk("tp6_slv_re", 32'(bus.slv_re), 32'd0);
    do_access(1'b0, 1'b0, 32'h0000_0100, 32'h0, 2, 32'h1234_5678, 0);
    @(negedge clk);
    chk("tp6_rdata", bus.cpu_rdata, 32'h1234_5678);

    // Randomised mix
    for (int t = 0; t < 150; t++) begin
      kind = $urandom_range(0, 9);
      a    = {4'($urandom_range(0, NS - 1)), 28'($urandom)};
      case (kind)
        0:       do_access(1'($urandom), 1'b1, a, $urandom, 1, 32'h0, 0);
        1:       do_access(1'($urandom), 1'b0, {4'($urandom_range(NS, 15)), a[27:0]},
                           $urandom, 1, 32'h0, 0);
        2:       do_access(1'($urandom), 1'b0, a, $urandom, 0, 32'h0, 0);
        default: do_access(1'($urandom), 1'b0, a, $urandom, $urandom_range(1, TMO),
                           $urandom, 0);
      endcase
      idle_cycles($urandom_range(0, 2));
    end

    // Saturation of the error counter
    for (int t = 0; t < 300; t++) begin
      do_access(1'b1, 1'b1, {4'($urandom_range(0, 15)), 28'($urandom)}, $urandom, 1, 32'h0, 0);
    end
    @(negedge clk);
    chk("tp5_err_count", 32'(err_count), 32'h0000_00FF);

    idle_cycles(3);
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/io_bus_ctrl.md
Name: io_bus_ctrl

Overview:
- Parametrised memory-mapped I/O bus controller between the pipeline CPU's data port and NUM_SLV peripheral slaves (RAM, VRAM, ROM, switches/7-seg, keyboard, ...).
- Replaces fixed-latency decoding with a request/ack handshake:
  - CPU stall while an access is outstanding;
  - per-access timeout;
  - decode/timeout error reporting with a saturating error counter and last-error address capture.

Parameters:
- NUM_SLV, 4, number of slave channels (1..16).
- ADDR_W, 32, CPU address width.
- DATA_W, 32, data width.
- SEL_LSB, 28, LSB of the region-select field in cpu_addr.
- SEL_W, 4, width of the region-select field; region index = cpu_addr[SEL_LSB+SEL_W-1:SEL_LSB].
- TIMEOUT, 15, maximum WAIT cycles without ack before the access aborts (1..255).
- ERRCNT_W, 8, error counter width.

Ports:
- clk  in  1  single bus clock.
- rstn  in  1  asynchronous active-low reset.
- cpu_addr  in  ADDR_W  access address.
- cpu_re  in  1  read request (level, held while cpu_stall=1).
- cpu_we  in  1  write request (level, held while cpu_stall=1).
- cpu_wdata  in  DATA_W  write data.
- cpu_rdata  out  DATA_W  read data, valid in DONE cycle.
- cpu_stall  out  1  CPU must hold the request and freeze.
- cpu_err  out  1  access failed, valid in DONE cycle.
- slv_addr  out  ADDR_W  latched address, shared by all slaves.
- slv_wdata  out  DATA_W  latched write data, shared by all slaves.
- slv_re  out  NUM_SLV  one-hot read strobe.
- slv_we  out  NUM_SLV  one-hot write strobe.
- slv_rdata  in  NUM_SLV*DATA_W  flattened read data; slave i occupies [i*DATA_W +: DATA_W].
- slv_ack  in  NUM_SLV  per-slave completion.
- err_count  out  ERRCNT_W  saturating error count.
- err_addr  out  ADDR_W  address of the most recent failed access.

Behaviour:
- Reset (rstn=0, async): state=IDLE. All registered outputs are 0 (cpu_rdata, cpu_err, slv_addr, slv_wdata, slv_re, slv_we, err_count, err_addr). Reset mid-access drops all strobes immediately; the slave's late ack is ignored after release.
- Request: req = cpu_re | cpu_we. If both are asserted, the access is a decode error (no strobe).
- cpu_stall is combinational: (IDLE & req) | WAIT. It is 0 in DONE.
- IDLE:
  - On req with a valid index (idx < NUM_SLV, single op): latch addr, wdata, idx and op; go to WAIT.
  - On req with an invalid index or both ops: go to DONE with err.
  - With no req: stay in IDLE.
- WAIT:
  - slv_re[idx] or slv_we[idx] is registered high for every WAIT cycle (level strobe). The other strobe bits are 0.
  - The timeout counter starts at 0 on WAIT entry and increments per cycle.
  - slv_ack[idx]=1: capture slv_rdata slice idx into cpu_rdata (reads only; writes leave cpu_rdata=0); cpu_err=0; go to DONE. Strobes drop on the DONE cycle.
  - Counter == TIMEOUT-1 with no ack: go to DONE with cpu_err=1, cpu_rdata=0.
  - Ack bits from non-selected slaves are ignored.
- DONE (1 cycle): cpu_rdata and cpu_err are valid, stall=0. Always returns to IDLE. A req seen in the following IDLE is a new access.
- Minimum access: 2 stall cycles (IDLE, WAIT with immediate ack), then DONE.
- Error path, on any error entering DONE:
  - err_addr <= cpu_addr (decode error) or the latched addr (timeout);
  - err_count increments and saturates at all-ones.
- cpu_rdata and cpu_err hold their values until the next DONE.

Decomposition:
- Package io_bus_pkg:
  - state enum {IDLE, WAIT, DONE};
  - op encoding;
  - SEL-field helper constants;
  - error-data constant 0.
- One sub-module, io_bus_decode (combinational):
  - inputs: cpu_addr, cpu_re, cpu_we;
  - outputs: idx, valid, op.
- The FSM, timeout counter, read mux and error logging stay in io_bus_ctrl.

Test Plan:
- Read slave 1 at 0x1000_0010, ack on 1st WAIT cycle with slv_rdata[1]=0xCAFEF00D -> stall high for 2 cycles; DONE: cpu_rdata=0xCAFEF00D, cpu_err=0; slv_re=4'b0010 exactly one cycle.
- Write 0x0000_00AA to slave 2 at 0x2000_0000, ack after 5 WAIT cycles -> slv_we=4'b0100 for 5 cycles, slv_wdata=0xAA, stall 6 cycles, cpu_err=0.
- Read 0x7000_0000 (NUM_SLV=4) -> no strobes; DONE next cycle with cpu_err=1; err_addr=0x7000_0000; err_count=1.
- Read slave 3, never acked -> abort after 15 WAIT cycles, cpu_err=1, cpu_rdata=0; an ack from slave 0 mid-wait is ignored.
- Force 300 decode errors -> err_count saturates at 0xFF.
- Assert rstn=0 during WAIT on slave 0 -> strobes 0 asynchronously, state IDLE; an ack after release has no effect; next read completes normally.
